booth_mul_seq: RTL and testbench
================================

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1, operand pair offered.
REQ-004 SHALL have port in_ready, output, 1, block accepts operands.
REQ-005 SHALL have port a, input, 16, multiplicand, two's complement.
REQ-006 SHALL have port b, input, 16, multiplier, two's complement, Booth-recoded.
REQ-007 SHALL have port out_valid, output, 1, product available.
REQ-008 SHALL have port out_ready, input, 1, consumer takes product.
REQ-009 SHALL have port product, output, 32, two's-complement a*b.
REQ-010 SHALL have port busy, output, 1, high in CALC or DONE.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-013 SHALL accept operands when in_valid&&in_ready at a rising edge:
- latch a and b
- clear the 32-bit accumulator and the 3-bit digit counter cnt
- go to CALC
REQ-014 SHALL process one radix-4 Booth digit per CALC cycle:
- code={b[2cnt+1],b[2cnt],b[2cnt-1]}, with b[-1]=0
- digit: 000/111 -> 0; 001/010 -> +1; 011 -> +2; 100 -> -2; 101/110 -> -1
REQ-015 SHALL, each CALC cycle, add to the accumulator the partial product digit*a, sign-extended to 32 bits and shifted left 2*cnt, with modulo-2^32 wrap; negation is two's complement.
REQ-016 SHALL, in CALC, increment cnt and go to DONE after the cnt==7 cycle, giving exactly 8 CALC cycles without early termination.
REQ-017 SHALL make out_valid first high in the 9th cycle after the accepting edge (no early termination).
REQ-018 SHALL drive product from the accumulator; product SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 SHALL, in DONE, go to IDLE on out_valid&&out_ready; out_ready SHALL be ignored outside DONE.
REQ-020 SHALL accept a new operand pair no earlier than the cycle after the product handshake; in_valid in CALC/DONE SHALL be ignored.
REQ-021 SHALL ignore changes on a/b after acceptance.
REQ-022 SHALL return the exact result for -32768*-32768 = 0x40000000, which needs no overflow handling.

Reset
REQ-023 SHALL, with rst=1 at a rising edge:
- set state to IDLE, and accumulator, cnt and latched operands to 0
- set in_ready=1, out_valid=0, busy=0, product=0
REQ-024 SHALL abort any CALC or DONE operation when rst is asserted mid-operation; the result SHALL be discarded and no out_valid pulse produced.
REQ-025 SHALL give rst priority over a simultaneous input or output handshake.

Configuration
REQ-026 SHALL compile early termination in only when macro BOOTH_MUL_SEQ_EARLY_TERM_EN is defined.
REQ-027 SHALL, with the macro defined, go from CALC to DONE after the current digit when cnt==7 or latched b[15:2cnt+1] are all equal (all remaining digits zero):
- CALC length SHALL be 1..8 cycles
- product SHALL be identical to the non-terminated result
REQ-028 SHALL, without the macro, always use exactly 8 CALC cycles.

Verification
REQ-029 SHALL cover: a=0x7FFF, b=0x7FFF -> product 0x3FFF0001; out_valid in the 9th cycle after accept (macro off).
REQ-030 SHALL cover: a=0x8000, b=0x8000 -> product 0x40000000; always 8 CALC cycles.
REQ-031 SHALL cover: a=1234, b=0xFFFF -> product 0xFFFFFB2E; macro on: 1 CALC cycle, out_valid in the 2nd cycle after accept.
REQ-032 SHALL cover: a=0x0005, b=0x0003 -> 0x0000000F; macro on: 2 CALC cycles; b=0 -> product 0 after 1 CALC cycle.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles in DONE -> product and out_valid stable; in_ready=0 and in_valid ignored throughout; IDLE one cycle after the handshake.
REQ-034 SHALL cover: rst pulsed at the 4th CALC cycle -> the next cycle shows IDLE, in_ready=1, out_valid=0, product=0; a following a=-3, b=7 -> 0xFFFFFFEB.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Sequential 16x16 signed multiplier, one radix-4 Booth digit per cycle.
// Optional macro BOOTH_MUL_SEQ_EARLY_TERM_EN stops once all remaining digits are zero.
`timescale 1ns/1ps
module booth_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        busy
);

    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [2:0]          code;
    logic [PROD_W-1:0]   a_ext;
    logic [PROD_W-1:0]   pp;
    logic                last_digit;
`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
    logic [OP_W-1:0]     rest;
`endif

    // Booth recoding of the current digit and its weighted partial product
    always_comb begin
        a_ext = PROD_W'($signed(a_q));
        code  = 3'({b_q, 1'b0} >> {cnt_q, 1'b0});
        case (code)
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
        pp = pp << {cnt_q, 1'b0};
    end

    // Last-digit detection; early exit when the unconsumed multiplier bits are pure sign
`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
    always_comb begin
        rest       = $signed(b_q) >>> ({1'b0, cnt_q, 1'b0} + 5'd1);
        last_digit = (cnt_q == CNT_W'(7)) || (rest == '0) || (rest == '1);
    end
`else
    always_comb begin
        last_digit = (cnt_q == CNT_W'(7));
    end
`endif

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + pp;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = acc_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corner cases plus randomized operands
// against an arithmetic reference model.
`timescale 1ns/1ps
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;

    booth_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycles from accept edge to first out_valid: CALC digits plus one
    function automatic int exp_latency(input logic [15:0] bv);
        int k_needed;
        k_needed = 8;
`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
        begin
            int v;
            v = int'($signed(bv));
            for (int k = 8; k >= 1; k--) begin
                if (v >= -(1 << (2*k-1)) && v < (1 << (2*k-1))) k_needed = k;
            end
        end
`endif
        return k_needed + 1;
    endfunction

    function automatic logic [31:0] exp_product(input logic [15:0] av, input logic [15:0] bv);
        int p;
        p = int'($signed(av)) * int'($signed(bv));
        return 32'(p);
    endfunction

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input int stall);
        int          cyc;
        logic [31:0] expp;
        expp = exp_product(av, bv);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc      = 1;
        while (!out_valid && cyc < 20) begin
            check("in_ready_calc", 32'(in_ready), 32'd0);
            check("busy_calc", 32'(busy), 32'd1);
            in_valid  = 1'($urandom_range(0, 1));
            a         = 16'($urandom);
            b         = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("latency", 32'(cyc), 32'(exp_latency(bv)));
        check("product", product, expp);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = 16'($urandom);
            b        = 16'($urandom);
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_product", product, expp);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;
        logic [15:0] bv;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", product, 32'd0);

        run_op(16'h7FFF, 16'h7FFF, 0);
        check("max_pos_ref", exp_product(16'h7FFF, 16'h7FFF), 32'h3FFF0001);
        run_op(16'h8000, 16'h8000, 1);
        run_op(16'd1234, 16'hFFFF, 0);
        run_op(16'h0005, 16'h0003, 2);
        run_op(16'h1234, 16'h0000, 0);
        run_op(16'hABCD, 16'h0001, 5);

        // Reset during the 4th CALC cycle discards the operation
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h7FFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_product", product, 32'd0);
        seen_valid = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("abort_no_valid", 32'(seen_valid), 32'd0);
        run_op(16'hFFFD, 16'h0007, 0);
        check("neg_ref", exp_product(16'hFFFD, 16'h0007), 32'hFFFFFFEB);

        for (int n = 0; n < 60; n++) begin
            bv = 16'($urandom);
            if ($urandom_range(0, 1) == 1) bv = 16'($signed(bv) >>> $urandom_range(1, 15));
            run_op(16'($urandom), bv, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
